// File: rtl/if_id_stage_if.sv
// Fetch/decode boundary bus for the IF/ID pipeline stage.
//
// Handshake rules (both sides): a transfer happens on a rising clk edge when
// valid and ready are both 1. The producer holds valid and its payload
// stable until that transfer. Ready is allowed to be low while valid is low.
// For the fetch side, valid = f_valid and ready = f_ready. For the decode
// side, valid = d_valid and ready = d_ready.
//
// The slave modport is the stage's own view. The master modport is the view
// of the surrounding core (fetch plus decode) or of a testbench.
interface if_id_stage_if #(
  parameter int XLEN = 32
);
  // fetch side
  logic            f_valid;
  logic            f_ready;
  logic [XLEN-1:0] f_pc;
  logic [XLEN-1:0] f_inst;
  // redirect
  logic            flush;
  // decode side
  logic            d_valid;
  logic            d_ready;
  logic [XLEN-1:0] d_pc;
  logic [XLEN-1:0] d_inst;
  logic [4:0]      d_rs1;
  logic [4:0]      d_rs2;
  logic [4:0]      d_rd;
  logic            d_illegal;

  modport slave (
    input  f_valid, f_pc, f_inst, flush, d_ready,
    output f_ready, d_valid, d_pc, d_inst, d_rs1, d_rs2, d_rd, d_illegal
  );

  modport master (
    output f_valid, f_pc, f_inst, flush, d_ready,
    input  f_ready, d_valid, d_pc, d_inst, d_rs1, d_rs2, d_rd, d_illegal
  );
endinterface

// File: rtl/if_id_stage.sv
// IF/ID pipeline boundary with a two-entry skid buffer.
// The main register drives the decode side. The skid register catches the
// one extra entry that fetch may push in the cycle that decode stalls.
// Because of this, f_ready is a plain flop and does not form a combinational
// path from d_ready. Flush is synchronous and overrides every other action.
// Optional build macro IF_ID_PERF_EN: adds the counters perf_stall_cnt and
// perf_flush_cnt.
module if_id_stage #(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] NOP_INST = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rstn,
  if_id_stage_if.slave bus,
  output logic [1:0]  dbg_state_o
`ifdef IF_ID_PERF_EN
  ,
  output logic [31:0] perf_stall_cnt,
  output logic [31:0] perf_flush_cnt
`endif
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_e;

  state_e          state_q;
  logic            f_ready_q;
  logic            d_valid_q;
  logic [XLEN-1:0] main_pc_q;
  logic [XLEN-1:0] main_inst_q;
  logic [XLEN-1:0] skid_pc_q;
  logic [XLEN-1:0] skid_inst_q;

  logic accept;
  logic consume;

  assign accept  = bus.f_valid & f_ready_q;
  assign consume = d_valid_q & bus.d_ready;

  // Skid FSM. Every output is registered. While the stage holds no valid
  // entry, main stays at pc=0 and inst=NOP_INST.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= EMPTY;
      f_ready_q   <= 1'b1;
      d_valid_q   <= 1'b0;
      main_pc_q   <= '0;
      main_inst_q <= NOP_INST;
      skid_pc_q   <= '0;
      skid_inst_q <= NOP_INST;
    end else if (bus.flush) begin
      state_q     <= EMPTY;
      f_ready_q   <= 1'b1;
      d_valid_q   <= 1'b0;
      main_pc_q   <= '0;
      main_inst_q <= NOP_INST;
    end else begin
      case (state_q)
        EMPTY: begin
          if (accept) begin
            state_q     <= ONE;
            d_valid_q   <= 1'b1;
            main_pc_q   <= bus.f_pc;
            main_inst_q <= bus.f_inst;
          end
        end
        ONE: begin
          if (accept && consume) begin
            main_pc_q   <= bus.f_pc;
            main_inst_q <= bus.f_inst;
          end else if (accept) begin
            state_q     <= TWO;
            f_ready_q   <= 1'b0;
            skid_pc_q   <= bus.f_pc;
            skid_inst_q <= bus.f_inst;
          end else if (consume) begin
            state_q     <= EMPTY;
            d_valid_q   <= 1'b0;
            main_pc_q   <= '0;
            main_inst_q <= NOP_INST;
          end
        end
        TWO: begin
          if (consume) begin
            state_q     <= ONE;
            f_ready_q   <= 1'b1;
            main_pc_q   <= skid_pc_q;
            main_inst_q <= skid_inst_q;
          end
        end
        default: begin
          state_q     <= EMPTY;
          f_ready_q   <= 1'b1;
          d_valid_q   <= 1'b0;
          main_pc_q   <= '0;
          main_inst_q <= NOP_INST;
        end
      endcase
    end
  end

  assign bus.f_ready   = f_ready_q;
  assign bus.d_valid   = d_valid_q;
  assign bus.d_pc      = main_pc_q;
  assign bus.d_inst    = main_inst_q;
  assign bus.d_rs1     = main_inst_q[19:15];
  assign bus.d_rs2     = main_inst_q[24:20];
  assign bus.d_rd      = main_inst_q[11:7];
  assign bus.d_illegal = d_valid_q & (main_inst_q[1:0] != 2'b11);
  assign dbg_state_o   = state_q;

`ifdef IF_ID_PERF_EN
  logic [31:0] stall_cnt_q;
  logic [31:0] flush_cnt_q;

  // Count decode stall cycles and flush cycles. Both counters wrap freely.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (d_valid_q && !bus.d_ready) stall_cnt_q <= stall_cnt_q + 32'd1;
      if (bus.flush)                 flush_cnt_q <= flush_cnt_q + 32'd1;
    end
  end

  assign perf_stall_cnt = stall_cnt_q;
  assign perf_flush_cnt = flush_cnt_q;
`endif

endmodule

// File: tb/tb_if_id_stage.sv
// Self-checking bench for if_id_stage: directed scenarios plus a randomized
// stream, with a FIFO scoreboard of {pc, inst} entries.
module tb_if_id_stage;
  localparam int          XLEN = 32;
  localparam logic [31:0] NOP  = 32'h0000_0013;

  logic clk;
  logic rstn;
  logic [1:0] dbg_state;
`ifdef IF_ID_PERF_EN
  logic [31:0] perf_stall_cnt;
  logic [31:0] perf_flush_cnt;
`endif

  if_id_stage_if #(.XLEN(XLEN)) bus ();

  if_id_stage #(.XLEN(XLEN), .NOP_INST(NOP)) dut (
    .clk         (clk),
    .rstn        (rstn),
    .bus         (bus),
    .dbg_state_o (dbg_state)
`ifdef IF_ID_PERF_EN
    ,
    .perf_stall_cnt (perf_stall_cnt),
    .perf_flush_cnt (perf_flush_cnt)
`endif
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- checking ----------------
  int err_cnt = 0;
  int chk_cnt = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    chk_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got=0x%0h expected=0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- scoreboard ----------------
  logic [63:0] exp_q[$];
  logic        mon_en = 1'b0;

  always @(negedge rstn) exp_q.delete();

  // The monitor samples on the falling edge. It first checks the outputs
  // against the modelled FIFO. It then applies the transfers that the next
  // rising edge will perform.
  always @(negedge clk) begin
    int          n;
    logic [63:0] head;
    logic [31:0] e_inst;
    logic        e_acc;
    logic        e_con;
    if (mon_en && rstn) begin
      n = exp_q.size();
      head = 64'd0;
      check("mon_d_valid", 64'(bus.d_valid), 64'(n != 0));
      check("mon_f_ready", 64'(bus.f_ready), 64'(n < 2));
      if (n != 0) begin
        head = exp_q[0];
        e_inst = head[31:0];
        check("mon_d_pc", 64'(bus.d_pc), 64'(head[63:32]));
      end else begin
        e_inst = NOP;
        check("mon_idle_pc", 64'(bus.d_pc), 64'd0);
      end
      check("mon_d_inst", 64'(bus.d_inst), 64'(e_inst));
      check("mon_d_rs1", 64'(bus.d_rs1), 64'(e_inst[19:15]));
      check("mon_d_rs2", 64'(bus.d_rs2), 64'(e_inst[24:20]));
      check("mon_d_rd", 64'(bus.d_rd), 64'(e_inst[11:7]));
      check("mon_d_illegal", 64'(bus.d_illegal), 64'((n != 0) && (e_inst[1:0] != 2'b11)));
      e_con = (n != 0) && bus.d_ready;
      e_acc = bus.f_valid && (n < 2);
      if (bus.flush) begin
        exp_q.delete();
      end else begin
        if (e_con) void'(exp_q.pop_front());
        if (e_acc) exp_q.push_back({bus.f_pc, bus.f_inst});
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_f(input logic v, input logic [31:0] pc, input logic [31:0] inst);
    bus.f_valid = v;
    bus.f_pc    = pc;
    bus.f_inst  = inst;
  endtask

  task automatic go_idle();
    drive_f(1'b0, 32'hx, 32'hx);
    bus.d_ready = 1'b1;
    bus.flush   = 1'b1;
    tick();
    bus.flush   = 1'b0;
  endtask

  logic [31:0] stream_inst [4] = '{32'h00500093, 32'h00a00113, 32'h00f00193, 32'h01400213};
`ifdef IF_ID_PERF_EN
  logic [31:0] stall0, flush0;
`endif

  // ---------------- stimulus ----------------
  initial begin
    rstn = 1'b0;
    drive_f(1'b0, 32'h0, 32'h0);
    bus.flush   = 1'b0;
    bus.d_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    // reset state
    check("rst_f_ready", 64'(bus.f_ready), 64'd1);
    check("rst_d_valid", 64'(bus.d_valid), 64'd0);
    check("rst_d_pc", 64'(bus.d_pc), 64'd0);
    check("rst_d_inst", 64'(bus.d_inst), 64'(NOP));
    check("rst_fields", 64'({bus.d_rs1, bus.d_rs2, bus.d_rd}), 64'd0);
    check("rst_illegal", 64'(bus.d_illegal), 64'd0);
    check("rst_state", 64'(dbg_state), 64'd0);
    rstn   = 1'b1;
    mon_en = 1'b1;

    // stream at full rate
    bus.d_ready = 1'b1;
    drive_f(1'b1, 32'h0, stream_inst[0]);
    tick();
    check("stream_valid0", 64'(bus.d_valid), 64'd1);
    check("stream_pc0", 64'(bus.d_pc), 64'h0);
    check("stream_rd0", 64'(bus.d_rd), 64'd1);
    drive_f(1'b1, 32'h4, stream_inst[1]);
    tick();
    check("stream_pc1", 64'(bus.d_pc), 64'h4);
    check("stream_rd1", 64'(bus.d_rd), 64'd2);
    check("stream_f_ready", 64'(bus.f_ready), 64'd1);

    // backpressure for three cycles
    bus.d_ready = 1'b0;
    drive_f(1'b1, 32'h8, stream_inst[2]);
    tick();
    check("bp_hold_pc_a", 64'(bus.d_pc), 64'h4);
    check("bp_f_ready", 64'(bus.f_ready), 64'd0);
    check("bp_state_two", 64'(dbg_state), 64'd2);
    drive_f(1'b1, 32'hC, stream_inst[3]);
    tick();
    check("bp_hold_pc_b", 64'(bus.d_pc), 64'h4);
    tick();
    check("bp_hold_pc_c", 64'(bus.d_pc), 64'h4);
    bus.d_ready = 1'b1;
    tick();
    check("bp_release_pc8", 64'(bus.d_pc), 64'h8);
    check("bp_release_f_ready", 64'(bus.f_ready), 64'd1);
    tick();
    check("bp_release_pcC", 64'(bus.d_pc), 64'hC);
    go_idle();

    // flush while both entries are held
    bus.d_ready = 1'b0;
    drive_f(1'b1, 32'h10, 32'h00100093);
    tick();
    drive_f(1'b1, 32'h14, 32'h00200113);
    tick();
    check("fl_state_two", 64'(dbg_state), 64'd2);
    drive_f(1'b1, 32'h18, 32'h00300193);
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;
    drive_f(1'b0, 32'hx, 32'hx);
    check("fl_d_valid", 64'(bus.d_valid), 64'd0);
    check("fl_d_inst", 64'(bus.d_inst), 64'h13);
    check("fl_f_ready", 64'(bus.f_ready), 64'd1);
    tick();
    check("fl_no_0x18", 64'(bus.d_valid), 64'd0);
    drive_f(1'b1, 32'h40, 32'h00400213);
    tick();
    check("fl_after_pc", 64'(bus.d_pc), 64'h40);

    // illegal flag
    bus.d_ready = 1'b1;
    drive_f(1'b1, 32'h44, 32'h00000000);
    tick();
    check("ill_zero", 64'(bus.d_illegal), 64'd1);
    drive_f(1'b1, 32'h48, 32'h00000013);
    tick();
    check("ill_nop", 64'(bus.d_illegal), 64'd0);
    drive_f(1'b0, 32'hx, 32'hx);
    tick();
    check("ill_idle", 64'(bus.d_illegal), 64'd0);

    // asynchronous reset pulse while stalled with two entries held
    bus.d_ready = 1'b0;
    drive_f(1'b1, 32'h80, 32'h00500093);
    tick();
    drive_f(1'b1, 32'h84, 32'h00a00113);
    tick();
    drive_f(1'b0, 32'hx, 32'hx);
    check("ar_state_two", 64'(dbg_state), 64'd2);
    #2 rstn = 1'b0;
    #1;
    check("ar_d_valid", 64'(bus.d_valid), 64'd0);
    check("ar_f_ready", 64'(bus.f_ready), 64'd1);
    check("ar_d_inst", 64'(bus.d_inst), 64'(NOP));
    rstn = 1'b1;
    bus.d_ready = 1'b1;
    drive_f(1'b1, 32'h0, 32'h00700393);
    tick();
    check("ar_first_pc", 64'(bus.d_pc), 64'h0);
    check("ar_first_valid", 64'(bus.d_valid), 64'd1);
    go_idle();

`ifdef IF_ID_PERF_EN
    // counter increments across three stall cycles and one flush
    bus.d_ready = 1'b0;
    drive_f(1'b1, 32'h100, 32'h00100093);
    tick();
    drive_f(1'b0, 32'hx, 32'hx);
    stall0 = perf_stall_cnt;
    flush0 = perf_flush_cnt;
    repeat (3) tick();
    bus.d_ready = 1'b1;
    bus.flush   = 1'b1;
    tick();
    bus.flush   = 1'b0;
    check("perf_stall", 64'(perf_stall_cnt - stall0), 64'd3);
    check("perf_flush", 64'(perf_flush_cnt - flush0), 64'd1);
`endif

    // randomized traffic with occasional flushes
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 3) != 0)
        drive_f(1'b1, $urandom, $urandom);
      else
        drive_f(1'b0, 32'hx, 32'hx);
      bus.d_ready = ($urandom_range(0, 2) != 0);
      bus.flush   = ($urandom_range(0, 24) == 0);
      tick();
    end
    bus.flush = 1'b0;
    drive_f(1'b0, 32'h0, 32'h0);
    bus.d_ready = 1'b1;
    repeat (3) tick();
    check("drain_empty", 64'(bus.d_valid), 64'd0);

    mon_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end
endmodule
